// File: rtl/snow64_lar_line_packer_pkg.sv
// Shared types for the LAR line packer: line/scalar/offset types, FSM state,
// start/output bundles and element-width helpers.
package PkgSnow64LarLinePacker;

    localparam int LAR_DATA_WIDTH_P = 256;
    localparam int SCALAR_WIDTH_P   = 64;
    localparam int OFFSET_WIDTH_P   = 5;
    localparam int LINE_BYTES       = LAR_DATA_WIDTH_P / 8;

    typedef logic [LAR_DATA_WIDTH_P-1:0] LarData;
    typedef logic [SCALAR_WIDTH_P-1:0]   ScalarData;
    typedef logic [OFFSET_WIDTH_P-1:0]   DataOffset;

    localparam logic [1:0] DT_UINT     = 2'd0;
    localparam logic [1:0] DT_SINT     = 2'd1;
    localparam logic [1:0] DT_BFLOAT16 = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        OUTPUT = 2'd2
    } StatePacker;

    typedef struct packed {
        LarData                  line;
        logic [1:0]              data_type;
        logic [1:0]              int_type_size;
        DataOffset               offset;
        logic [OFFSET_WIDTH_P:0] count;
    } PortIn_LarLinePackerStart;

    typedef struct packed {
        logic   valid;
        LarData data;
    } PortOut_LarLinePacker;

    // log2 of the element width in bytes; bfloat16 is always 2 bytes.
    function automatic logic [1:0] elem_log2(input logic [1:0] data_type,
                                             input logic [1:0] int_type_size);
        return (data_type == DT_BFLOAT16) ? 2'd1 : int_type_size;
    endfunction

    function automatic logic [3:0] elem_bytes(input logic [1:0] data_type,
                                              input logic [1:0] int_type_size);
        return 4'd1 << elem_log2(data_type, int_type_size);
    endfunction

endpackage

// File: rtl/snow64_lar_lane_merge.sv
// Overwrites `width` bytes of a line at byte `offset` with the low bytes of a scalar.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module snow64_lar_lane_merge
    import PkgSnow64LarLinePacker::*;
(
    input  LarData     line,
    input  ScalarData  scalar,
    input  DataOffset  offset,
    input  logic [3:0] width,
    output LarData     merged
);

    logic [5:0] rel;

    // Bytes before the offset wrap rel to >= 33, so the single compare covers both bounds.
    always_comb begin
        merged = line;
        rel    = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            rel = 6'(i) - {1'b0, offset};
            if (rel < {2'b00, width}) begin
                merged[i*8 +: 8] = scalar[{rel[2:0], 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/snow64_lar_line_packer.sv
// Packs a stream of scalars into one LAR line at successive type-aligned offsets.
// Latency: 1 start cycle + 1 cycle per element, out_valid the cycle after the last accept.
// Backpressure: in_ready only in FILL; the line is held in OUTPUT until out_ready.
module snow64_lar_line_packer
    import PkgSnow64LarLinePacker::*;
#(
    parameter int LAR_DATA_WIDTH = 256,
    parameter int SCALAR_WIDTH   = 64,
    parameter int OFFSET_WIDTH   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LAR_DATA_WIDTH-1:0] start_line,
    input  logic [1:0]                start_data_type,
    input  logic [1:0]                start_int_type_size,
    input  logic [OFFSET_WIDTH-1:0]   start_offset,
    input  logic [OFFSET_WIDTH:0]     start_count,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SCALAR_WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LAR_DATA_WIDTH-1:0] out_data,
    output logic                      busy
);

    localparam logic [OFFSET_WIDTH:0] LINE_END = (OFFSET_WIDTH+1)'(LAR_DATA_WIDTH / 8);

    PortIn_LarLinePackerStart start_req;
    PortOut_LarLinePacker     out_port;

    StatePacker            state;
    LarData                line_q;
    logic [3:0]            width_q;
    logic [OFFSET_WIDTH:0] offset_q;
    logic [OFFSET_WIDTH:0] remaining_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [3:0]            start_width;
    logic [1:0]            start_log2;
    DataOffset             start_aligned;
    logic [OFFSET_WIDTH:0] start_space;
    logic [OFFSET_WIDTH:0] start_remaining;
    logic [OFFSET_WIDTH:0] next_offset;
    logic                  accept;
    logic                  last_elem;
    LarData                merged_line;

    assign start_req = '{
        line:          start_line,
        data_type:     start_data_type,
        int_type_size: start_int_type_size,
        offset:        start_offset,
        count:         start_count
    };

    always_comb begin
        start_width     = elem_bytes(start_req.data_type, start_req.int_type_size);
        start_log2      = elem_log2(start_req.data_type, start_req.int_type_size);
        start_aligned   = start_req.offset & ~DataOffset'(start_width - 4'd1);
        start_space     = (LINE_END - {1'b0, start_aligned}) >> start_log2;
        start_remaining = (start_req.count == '0) ? start_space : start_req.count;
    end

    // Oversized counts are cut off by the line-end test rather than clamped at start.
    assign accept      = in_valid && in_ready_q;
    assign next_offset = offset_q + {2'b00, width_q};
    assign last_elem   = (remaining_q == (OFFSET_WIDTH+1)'(1)) || (next_offset >= LINE_END);

    snow64_lar_lane_merge u_lane_merge (
        .line   (line_q),
        .scalar (in_data),
        .offset (offset_q[OFFSET_WIDTH-1:0]),
        .width  (width_q),
        .merged (merged_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            line_q      <= '0;
            width_q     <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FILL;
                        line_q      <= start_req.line;
                        width_q     <= start_width;
                        offset_q    <= {1'b0, start_aligned};
                        remaining_q <= start_remaining;
                        in_ready_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        line_q      <= merged_line;
                        offset_q    <= next_offset;
                        remaining_q <= remaining_q - (OFFSET_WIDTH+1)'(1);
                        if (last_elem) begin
                            state       <= OUTPUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_port  = '{valid: out_valid_q, data: line_q};
    assign out_valid = out_port.valid;
    assign out_data  = out_port.data;
    assign in_ready  = in_ready_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_snow64_lar_line_packer.sv
// Directed bench for the LAR line packer with a byte-level model of the expected line.
module tb_snow64_lar_line_packer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] start_line;
    logic [1:0]   start_data_type;
    logic [1:0]   start_int_type_size;
    logic [4:0]   start_offset;
    logic [5:0]   start_count;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         busy;

    int           checks = 0;
    int           errors = 0;
    logic [255:0] exp_line = '0;
    logic [255:0] last_line = '0;

    snow64_lar_line_packer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .start_line          (start_line),
        .start_data_type     (start_data_type),
        .start_int_type_size (start_int_type_size),
        .start_offset        (start_offset),
        .start_count         (start_count),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte b of the k-th fed scalar; upper bytes differ so truncation is visible.
    function automatic logic [7:0] elem_byte(input int k, input int b);
        return 8'(8'h11 * (k + 1) + b);
    endfunction

    function automatic logic [63:0] feed(input int k);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = elem_byte(k, b);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("out_data", out_data, exp_line);
            chk("in_ready_in_output", {255'd0, in_ready}, 256'd0);
        end
    end

    task automatic run_job(input logic [255:0] line, input logic [1:0] dt, input logic [1:0] sz,
                           input logic [4:0] off, input logic [5:0] cnt, input int gap_mask,
                           input int stall, input bit mid_start, input int lit_n, input int lit_lat);
        int w, a, space, n, k, edges, i;
        logic [255:0] m;
        w     = (dt == 2'd2) ? 2 : (1 << sz);
        a     = int'(off) - (int'(off) % w);
        space = (32 - a) / w;
        n     = (cnt == 0) ? space : ((int'(cnt) < space) ? int'(cnt) : space);
        m     = line;
        for (int e = 0; e < n; e++)
            for (int b = 0; b < w; b++)
                m[(a + e*w + b)*8 +: 8] = elem_byte(e, b);
        exp_line = m;

        @(negedge clk);
        start = 1'b1; start_line = line; start_data_type = dt;
        start_int_type_size = sz; start_offset = off; start_count = cnt;
        @(negedge clk);
        start = 1'b0;
        edges = 1; k = 0; i = 0;
        chk("busy_fill", {255'd0, busy}, 256'd1);
        while (!out_valid && edges < 200) begin
            in_valid = (i < 32) ? !gap_mask[i] : 1'b1;
            in_data  = feed(k);
            if (mid_start && i == 1) begin
                start = 1'b1; start_offset = off ^ 5'h10; start_count = 6'd1;
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) k++;
            @(negedge clk);
            edges++; i++;
        end
        in_valid = 1'b0; start = 1'b0;
        last_line = out_data;
        chk("out_valid_timeout", {255'd0, out_valid}, 256'd1);
        chk("accepted", 256'(k), 256'(n));
        if (lit_n >= 0) chk("accepted_lit", 256'(k), 256'(lit_n));
        // Cycle count includes the cycle in which start is sampled.
        if (lit_lat >= 0) chk("latency", 256'(edges + 1), 256'(lit_lat));
        for (int s = 0; s < stall; s++) begin
            chk("hold_valid", {255'd0, out_valid}, 256'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", {255'd0, out_valid}, 256'd0);
        chk("idle_busy", {255'd0, busy}, 256'd0);
    endtask

    initial begin
        int k, guard;
        rst_n = 1'b0; start = 1'b0; start_line = '0; start_data_type = '0;
        start_int_type_size = '0; start_offset = '0; start_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
        chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_out_data", out_data, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8-bit uint, four bytes at offset 0
        run_job(256'd0, 2'd0, 2'd0, 5'd0, 6'd4, 0, 0, 1'b0, 4, 6);
        chk("t1_low32", {224'd0, last_line[31:0]}, 256'h44332211);
        chk("t1_upper", {32'd0, last_line[255:32]}, 256'd0);

        // 64-bit sint, offset 9 aligns to 8, fill to end
        run_job({32{8'hA5}}, 2'd1, 2'd3, 5'd9, 6'd0, 0, 0, 1'b0, 3, 5);
        chk("t2_bytes0_7", {192'd0, last_line[63:0]}, 256'hA5A5A5A5A5A5A5A5);
        chk("t2_byte8", {248'd0, last_line[71:64]}, 256'h11);

        // bfloat16 ignores int size; only bytes 30..31 fit
        run_job({32{8'h5A}}, 2'd2, 2'd3, 5'd30, 6'd5, 0, 0, 1'b0, 1, 3);
        chk("t3_top16", {240'd0, last_line[255:240]}, 256'h1211);

        // 32-bit with an input bubble and a 3-cycle output stall
        run_job({8{32'hCAFEF00D}}, 2'd0, 2'd2, 5'd4, 6'd2, 'b010, 3, 1'b0, 2, -1);
        chk("t4_word1", {224'd0, last_line[63:32]}, 256'h14131211);

        // start during FILL is ignored
        run_job({16{16'h0F0F}}, 2'd0, 2'd1, 5'd7, 6'd3, 0, 1, 1'b1, 3, 5);

        // reserved type acts as uint; count larger than space is truncated
        run_job({32{8'h3C}}, 2'd3, 2'd2, 5'd24, 6'd7, 0, 0, 1'b0, 2, 4);

        // abort after two of four elements
        @(negedge clk);
        start = 1'b1; start_line = {32{8'hFF}}; start_data_type = 2'd0;
        start_int_type_size = 2'd0; start_offset = 5'd0; start_count = 6'd4;
        @(negedge clk);
        start = 1'b0; k = 0; guard = 0;
        while (k < 2 && guard < 50) begin
            in_valid = 1'b1; in_data = feed(k);
            if (in_ready) k++;
            @(negedge clk);
            guard++;
        end
        chk("abort_accepts", 256'(k), 256'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {255'd0, in_ready}, 256'd0);
        chk("abort_out_valid", {255'd0, out_valid}, 256'd0);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_out_data", out_data, 256'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // fresh job after abort, 8-bit fill to end from offset 28
        run_job(256'd0, 2'd0, 2'd0, 5'd28, 6'd0, 0, 1, 1'b0, 4, 6);
        chk("t7_top32", {224'd0, last_line[255:224]}, 256'h44332211);
        chk("t7_rest", {32'd0, last_line[223:0]}, 256'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
